output_precision_selection: RTL and testbench
=============================================

Name: output_precision_selection

Overview:
- Output-side counterpart of input_precision_selection in xfire_fpu_bkm.
- Takes full-width W-bit signed BKM results (X real, Y imaginary) and reduces them to the precision selected by `format`. Reduction is round-half-up with saturation; the result is MSB-aligned with the low bits zeroed.
- 2-stage valid/ready pipeline between the BKM core and the writeback stage. Counts saturation events and flags reserved formats.

Parameters:
- W, 16, datapath width; must be a multiple of 4 and at least 8.
- CNT_W, 8, width of the saturation event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of sat_cnt and fmt_err; has no effect on the pipeline.
- format  in  2  precision select, sampled with each input transaction.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input.
- X_in  in  W  signed real result from the BKM core.
- Y_in  in  W  signed imaginary result from the BKM core.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts the output.
- X_out  out  W  signed reduced real part.
- Y_out  out  W  signed reduced imaginary part.
- sat_cnt  out  CNT_W  count of saturated transactions; saturates at all-ones.
- fmt_err  out  1  sticky flag: a reserved format was accepted.

Behaviour:
- Precision P by format:
  - 00 → W.
  - 01 → W/2.
  - 10 → W/4.
  - 11 → reserved; processed as 00 and sets fmt_err.
- Reduction per component, with R = W−P:
  - If R = 0: pass-through.
  - Else: sum = in + 2^(R−1), computed at W+1 bits, signed.
  - Overflow when sum > 2^(W−1)−1. Result is then clamped to max_P = 0 followed by (W−1) ones, with the low R bits cleared.
  - Otherwise the result is sum[W−1:0] with the low R bits cleared.
  - Negative inputs cannot overflow.
- Stage 1 (S1): registers the reduced X, Y, sat flag and format_err flag when in_valid && in_ready.
- Stage 2 (S2): output register driving X_out, Y_out, out_valid.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv. Combinational; no combinational path from in_valid to in_ready.
- Latency is 2 cycles: input accepted at edge N appears on out_valid/X_out after edge N+1, and is consumed at edge N+2 or later.
- Full throughput (1 transaction per cycle) while out_ready = 1.
- Stall: while out_valid && !out_ready, X_out/Y_out/out_valid hold. S1 fills; then in_ready = 0. No transaction is dropped or duplicated.
- sat_cnt increments by 1 when a transaction with X or Y saturated is captured into S1 (once per transaction, not per component). It holds at 2^CNT_W−1.
- fmt_err is set when a format=11 transaction is captured into S1.
- clr has priority over increment/set in the same cycle; the result is 0.
- Reset (async, rst_n = 0):
  - S1/S2 valid = 0, so out_valid = 0 and in_ready = 1.
  - X_out = Y_out = 0, sat_cnt = 0, fmt_err = 0.
  - In-flight data is discarded. Reset mid-stall drops both stages.

Optional Feature:
- OUTPUT_PRECISION_ROUND_EN.
- Defined: round-half-up with saturation, as above.
- Undefined: truncation only. The low R bits are cleared with no addend, saturation never occurs, and sat_cnt stays 0.

Test Plan:
- Pass-through: W=16, format=00, X_in=16'h1234, Y_in=16'hFFFF, out_ready=1 → 2 cycles later X_out=16'h1234, Y_out=16'hFFFF; sat_cnt=0.
- Rounding, format=01:
  - X_in=16'h12C0 → X_out=16'h1300; with macro undefined → 16'h1200.
  - Y_in=16'hFF80 → Y_out=16'h0000.
  - Format=10, X_in=16'h1800 → X_out=16'h2000.
- Saturation, format=01, X_in=16'h7FC0, Y_in=16'h8000 → X_out=16'h7F00, Y_out=16'h8000, sat_cnt=1.
  - With CNT_W=2 and 5 such transactions → sat_cnt=3.
  - Assert clr → sat_cnt=0 next cycle.
- Backpressure:
  - Stream 8 distinct inputs, out_ready low for cycles 3–6 → in_ready low after S1 fills.
  - All 8 outputs appear in order, exactly once; X_out stable while stalled.
- Reserved format: format=11, X_in=16'h0123 → X_out=16'h0123, fmt_err=1 and sticky; clr → fmt_err=0.
- Reset mid-operation: rst_n low for 1 cycle with both stages full → out_valid=0, in_ready=1, X_out=0 immediately (async); stale data never emitted.

Source files
------------

// File: rtl/output_precision_selection.sv
// Reduces W-bit signed BKM results (X, Y) to the precision picked by `format`, in a 2-stage valid/ready pipeline.
// Define OUTPUT_PRECISION_ROUND_EN for round-half-up with saturation; otherwise the low bits are truncated.
module output_precision_selection #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [1:0]       format,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     X_in,
  input  logic [W-1:0]     Y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     X_out,
  output logic [W-1:0]     Y_out,
  output logic [CNT_W-1:0] sat_cnt,
  output logic             fmt_err
);

  localparam int RH = W / 2;
  localparam int RQ = (3 * W) / 4;

  // Returns {saturated, reduced value}. Format 11 takes the full-width path.
  function automatic logic [W:0] reduce_fn(input logic [W-1:0] v, input logic [1:0] fmt);
    logic [W-1:0] mask;
    mask = '1;
    case (fmt)
      2'b01:   mask = {{(W-RH){1'b1}}, {RH{1'b0}}};
      2'b10:   mask = {{(W-RQ){1'b1}}, {RQ{1'b0}}};
      default: mask = '1;
    endcase
`ifdef OUTPUT_PRECISION_ROUND_EN
    begin
      logic [W:0] half;
      logic [W:0] sum;
      // The top bit of the discarded field is the half-LSB addend; zero when nothing is discarded.
      half = {1'b0, ~mask & ~(~mask >> 1)};
      sum  = {v[W-1], v} + half;
      if (!sum[W] && sum[W-1]) return {1'b1, {1'b0, {(W-1){1'b1}}} & mask};
      return {1'b0, sum[W-1:0] & mask};
    end
`else
    return {1'b0, v & mask};
`endif
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     s2_x_q, s2_x_d, s2_y_q, s2_y_d;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic             fmt_err_q, fmt_err_d;

  logic             s2_adv, s1_adv, in_fire;
  logic [W:0]       rx, ry;

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
  // and a held valid keeps its data stable until accepted. in_ready depends only on state and out_ready.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = s1_valid_q && s2_adv;
    in_ready   = !s1_valid_q || s2_adv;
    in_fire    = in_valid && in_ready;
    rx         = reduce_fn(X_in, format);
    ry         = reduce_fn(Y_in, format);

    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s2_valid_d = s2_valid_q;
    s2_x_d     = s2_x_q;
    s2_y_d     = s2_y_q;
    sat_cnt_d  = sat_cnt_q;
    fmt_err_d  = fmt_err_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_x_d     = rx[W-1:0];
      s1_y_d     = ry[W-1:0];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_x_d     = s1_x_q;
      s2_y_d     = s1_y_q;
    end else if (s2_adv) begin
      s2_valid_d = 1'b0;
    end

    // One count per transaction even when both components saturate.
    if (clr) begin
      sat_cnt_d = '0;
      fmt_err_d = 1'b0;
    end else if (in_fire) begin
      if ((rx[W] || ry[W]) && (sat_cnt_q != {CNT_W{1'b1}})) sat_cnt_d = sat_cnt_q + 1'b1;
      if (format == 2'b11) fmt_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      sat_cnt_q  <= '0;
      fmt_err_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s2_valid_q <= s2_valid_d;
      s2_x_q     <= s2_x_d;
      s2_y_q     <= s2_y_d;
      sat_cnt_q  <= sat_cnt_d;
      fmt_err_q  <= fmt_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign X_out     = s2_x_q;
  assign Y_out     = s2_y_q;
  assign sat_cnt   = sat_cnt_q;
  assign fmt_err   = fmt_err_q;

endmodule

// File: tb/tb_output_precision_selection.sv
// Randomized bench for output_precision_selection: arithmetic reference model, expected queue and
// occupancy-based handshake checks; follows OUTPUT_PRECISION_ROUND_EN like the design.
module tb_output_precision_selection;

  localparam int W     = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic [1:0]       format = 2'b00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     X_in = '0;
  logic [W-1:0]     Y_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     X_out;
  logic [W-1:0]     Y_out;
  logic [CNT_W-1:0] sat_cnt;
  logic             fmt_err;

  output_precision_selection #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .format(format),
    .in_valid(in_valid), .in_ready(in_ready), .X_in(X_in), .Y_in(Y_in),
    .out_valid(out_valid), .out_ready(out_ready), .X_out(X_out), .Y_out(Y_out),
    .sat_cnt(sat_cnt), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int win_lo = 0;
  int win_hi = 0;
  logic [2*W-1:0] exp_q[$];
  int acc_q[$];
  int m_sat = 0;
  bit m_fmt = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference: quantize to a multiple of 2^R using floor((v + 2^(R-1)) / 2^R), clamp at the top.
  function automatic logic [W:0] model_one(input logic [1:0] f, input logic [W-1:0] v);
    int step;
    int val;
    int res;
    bit sat;
    step = (f == 2'b01) ? 256 : (f == 2'b10) ? 4096 : 1;
    val  = int'($signed(v));
    sat  = 1'b0;
`ifdef OUTPUT_PRECISION_ROUND_EN
    res = val + step / 2;
    res = res - (((res % step) + step) % step);
    if (res > 32767) begin
      res = 32768 - step;
      sat = 1'b1;
    end
`else
    res = val - (((val % step) + step) % step);
`endif
    return {sat, 16'(res)};
  endfunction

  function automatic bit pick_ready();
    case (rdy_mode)
      1: return ($urandom_range(0, 9) < 7);
      2: return !(cyc >= win_lo && cyc <= win_hi);
      3: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 4))
      0: return 16'h7F00 + 16'($urandom_range(0, 255));
      1: return 16'h8000 + 16'($urandom_range(0, 255));
      2: return 16'h7000 + 16'($urandom_range(0, 4095));
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock: drive at the falling edge, check just after, account for the coming rising edge.
  task automatic step(input bit iv, input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                      input bit c, output bit acc);
    logic [W:0] mx, my;
    @(negedge clk);
    in_valid  = iv;
    format    = f;
    X_in      = x;
    Y_in      = y;
    clr       = c;
    out_ready = pick_ready();
    #1;
    check("sat_cnt", 32'(sat_cnt), 32'(m_sat));
    check("fmt_err", 32'(fmt_err), 32'(m_fmt));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0 && acc_q[0] <= cyc - 2));
    check("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 2 && !out_ready)));
    if (out_valid && exp_q.size() > 0) begin
      check("X_out", 32'(X_out), 32'(exp_q[0][2*W-1:W]));
      check("Y_out", 32'(Y_out), 32'(exp_q[0][W-1:0]));
      if (out_ready) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
    end
    acc = iv && in_ready;
    mx  = model_one(f, x);
    my  = model_one(f, y);
    if (acc) begin
      exp_q.push_back({mx[W-1:0], my[W-1:0]});
      acc_q.push_back(cyc);
    end
    if (c) begin
      m_sat = 0;
      m_fmt = 1'b0;
    end else if (acc) begin
      if ((mx[W] || my[W]) && m_sat < 255) m_sat++;
      if (f == 2'b11) m_fmt = 1'b1;
    end
    cyc++;
  endtask

  task automatic send(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y, input bit c);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      step(1'b1, f, x, y, c, acc);
      guard++;
    end
    if (!acc) check("send_timeout", 32'(guard), 32'(0));
  endtask

  task automatic idle(input int n, input bit c);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, c, acc);
  endtask

  task automatic drain();
    int g;
    g = 0;
    rdy_mode = 0;
    while (exp_q.size() > 0 && g < 50) begin
      idle(1, 1'b0);
      g++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #2;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_X_out", 32'(X_out), 32'(0));
    check("rst_sat_cnt", 32'(sat_cnt), 32'(0));
    check("rst_fmt_err", 32'(fmt_err), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors from the block's examples.
    rdy_mode = 0;
    send(2'b00, 16'h1234, 16'hFFFF, 1'b0);
    send(2'b01, 16'h12C0, 16'hFF80, 1'b0);
    send(2'b10, 16'h1800, 16'h0000, 1'b0);
    send(2'b01, 16'h7FC0, 16'h8000, 1'b0);
    send(2'b11, 16'h0123, 16'h0000, 1'b0);
    send(2'b10, 16'h7FFF, 16'h8000, 1'b0);
    drain();
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Backpressure window while streaming 8 distinct values.
    rdy_mode = 2;
    win_lo = cyc + 3;
    win_hi = cyc + 6;
    for (int i = 0; i < 8; i++) send(2'(i % 3), 16'(16'h1100 * (i + 1) + 16'h0080), 16'(16'h8000 + i * 16'h0F40), 1'b0);
    drain();

    // Enough saturating transactions to pin the counter at all-ones.
    for (int i = 0; i < 260; i++) send(2'b01, 16'h7FC0, 16'h0000, 1'b0);
    drain();
    idle(1, 1'b1);

    // Random traffic with random backpressure and occasional clear.
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      send(2'($urandom_range(0, 3)), rand_val(), rand_val(), ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)), 1'b0);
    end
    drain();

    // Reset with both stages full and the output stalled.
    rdy_mode = 3;
    send(2'b00, 16'hAAAA, 16'h5555, 1'b0);
    send(2'b00, 16'hBBBB, 16'h4444, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_X_out", 32'(X_out), 32'(0));
    check("midrst_Y_out", 32'(Y_out), 32'(0));
    check("midrst_sat_cnt", 32'(sat_cnt), 32'(0));
    exp_q.delete();
    acc_q.delete();
    m_sat = 0;
    m_fmt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    idle(4, 1'b0);
    send(2'b01, 16'h12C0, 16'h0040, 1'b0);
    drain();
    idle(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
